// File: rtl/vga_pkg.sv
// Shared timing constants, control-bundle type and helpers for the VGA raster path.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Both syncs are asserted low on the connector.
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic active;
        logic hsN;
        logic vsN;
    } rasterCtl_t;

    localparam rasterCtl_t CTL_RESET = '{active: 1'b0, hsN: ~SYNC_ACTIVE, vsN: ~SYNC_ACTIVE};

    function automatic logic inWindow(input logic [COORD_W-1:0] value,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the raster generator, the colour stage and the DAC pins.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] oVGA_X;
    logic [COORD_W-1:0] oVGA_Y;
    logic               iRed;
    logic               iGreen;
    logic               iBlue;
    logic               oVGA_R;
    logic               oVGA_G;
    logic               oVGA_B;
    logic               oVGA_HS;
    logic               oVGA_VS;
    logic               oVGA_BLANK_N;
    logic               oFrame_Tick;
    logic [7:0]         oFrame_Cnt;

    modport master (
        output oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS,
               oVGA_BLANK_N, oFrame_Tick, oFrame_Cnt,
        input  iRed, iGreen, iBlue
    );

    modport slave (
        input  oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS,
               oVGA_BLANK_N, oFrame_Tick, oFrame_Cnt,
        output iRed, iGreen, iBlue
    );

endinterface

// File: rtl/vga_delay_line.sv
// N-deep, W-wide register pipe with a programmable asynchronous reset value.
module vga_delay_line #(
    parameter int           N       = 1,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         reset,
    input  logic         iVGA_CLK,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] stage_q [N];

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout_o = stage_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/blank decode aligned to the colour stage, registered pins.
// Define VGA_FRAME_CNT_EN to build the 8-bit frame counter; otherwise oFrame_Cnt is 0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PAT_LAT  = 1
) (
    input  logic             reset,
    input  logic             iVGA_CLK,
    vga_timing_gen_if.master vga
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] hCnt_q, hCnt_d;
    logic [COORD_W-1:0] vCnt_q, vCnt_d;
    logic               hWrap, vWrap, tickCond;
    rasterCtl_t         ctlStage0, ctlAligned;
    logic               red_q, green_q, blue_q, hs_q, vs_q, blankN_q, frameTick_q;

    // Both counters return to zero on the same edge at the end of the last line.
    always_comb begin
        hWrap  = (hCnt_q == H_LAST);
        vWrap  = (vCnt_q == V_LAST);
        hCnt_d = hWrap ? '0 : hCnt_q + COORD_W'(1);
        vCnt_d = vCnt_q;
        if (hWrap) vCnt_d = vWrap ? '0 : vCnt_q + COORD_W'(1);
    end

    always_comb begin
        ctlStage0.active = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
        ctlStage0.hsN    = inWindow(hCnt_q, HS_BEG, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        ctlStage0.vsN    = inWindow(vCnt_q, VS_BEG, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        tickCond         = (hCnt_q == '0) && (vCnt_q == V_ACT);
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    // Control bits wait here for the colour stage so both reach the pins together.
    vga_delay_line #(
        .N       (PAT_LAT),
        .W       ($bits(rasterCtl_t)),
        .RST_VAL (CTL_RESET)
    ) uCtlDelay (
        .reset    (reset),
        .iVGA_CLK (iVGA_CLK),
        .din_i    (ctlStage0),
        .dout_o   (ctlAligned)
    );

    // Pin register: colour masked by the aligned active flag; the frame tick is not delayed.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            red_q       <= 1'b0;
            green_q     <= 1'b0;
            blue_q      <= 1'b0;
            hs_q        <= ~SYNC_ACTIVE;
            vs_q        <= ~SYNC_ACTIVE;
            blankN_q    <= 1'b0;
            frameTick_q <= 1'b0;
        end else begin
            red_q       <= vga.iRed   & ctlAligned.active;
            green_q     <= vga.iGreen & ctlAligned.active;
            blue_q      <= vga.iBlue  & ctlAligned.active;
            hs_q        <= ctlAligned.hsN;
            vs_q        <= ctlAligned.vsN;
            blankN_q    <= ctlAligned.active;
            frameTick_q <= tickCond;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frameCnt_q;

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            frameCnt_q <= 8'd0;
        end else if (tickCond) begin
            frameCnt_q <= frameCnt_q + 8'd1;
        end
    end

    assign vga.oFrame_Cnt = frameCnt_q;
`else
    assign vga.oFrame_Cnt = 8'd0;
`endif

    assign vga.oVGA_X       = hCnt_q;
    assign vga.oVGA_Y       = vCnt_q;
    assign vga.oVGA_R       = red_q;
    assign vga.oVGA_G       = green_q;
    assign vga.oVGA_B       = blue_q;
    assign vga.oVGA_HS      = hs_q;
    assign vga.oVGA_VS      = vs_q;
    assign vga.oVGA_BLANK_N = blankN_q;
    assign vga.oFrame_Tick  = frameTick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 raster plus two shrunken rasters for frame-level checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic iVGA_CLK = 1'b0;
    logic reset    = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;

`ifdef VGA_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #20 iVGA_CLK = ~iVGA_CLK;

    vga_timing_gen_if busA ();
    vga_timing_gen_if busB ();
    vga_timing_gen_if busT ();

    vga_timing_gen dutA (.reset(reset), .iVGA_CLK(iVGA_CLK), .vga(busA));

    vga_timing_gen #(
        .H_ACTIVE(120), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(6),   .V_FP(2), .V_SYNC(2), .V_BP(3), .PAT_LAT(3)
    ) dutB (.reset(reset), .iVGA_CLK(iVGA_CLK), .vga(busB));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PAT_LAT(1)
    ) dutT (.reset(reset), .iVGA_CLK(iVGA_CLK), .vga(busT));

    // Three-cycle colour stage for dutB that lights green only at X == 100.
    logic [2:0] greenPipe = 3'b000;
    always @(posedge iVGA_CLK) greenPipe <= {greenPipe[1:0], (busB.oVGA_X == 10'd100)};
    assign busB.iGreen = greenPipe[2];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int holdCycles);
        @(negedge iVGA_CLK);
        reset = 1'b1;
        repeat (holdCycles) @(negedge iVGA_CLK);
        reset = 1'b0;
    endtask

    initial begin
        int  hsFirstLow, hsLowLine0, hsLowTotal, blankHighLine0, redBad, redBlankZero, coordBad;
        int  vsLowFrame0, tickCount, firstTick, secondTick, wrapGood, wrapBad, greenBad, greenPulses;
        int  prevX, prevY, ticks, firstTickT, cntBad, tickWideBad;
        bit  found, done, prevTick, expG;

        busA.iRed = 1'b1; busA.iGreen = 1'b0; busA.iBlue = 1'b0;
        busB.iRed = 1'b1; busB.iBlue = 1'b0;
        busT.iRed = 1'b0; busT.iGreen = 1'b0; busT.iBlue = 1'b0;

        repeat (10) @(negedge iVGA_CLK);
        checkOutput("rstX", busA.oVGA_X, 0);
        checkOutput("rstY", busA.oVGA_Y, 0);
        checkOutput("rstR", busA.oVGA_R, 0);
        checkOutput("rstHS", busA.oVGA_HS, 1);
        checkOutput("rstVS", busA.oVGA_VS, 1);
        checkOutput("rstBlankN", busA.oVGA_BLANK_N, 0);
        checkOutput("rstTick", busA.oFrame_Tick, 0);
        checkOutput("rstCnt", busA.oFrame_Cnt, 0);
        reset = 1'b0;
        @(negedge iVGA_CLK);
        checkOutput("firstEdgeX", busA.oVGA_X, 1);
        checkOutput("firstEdgeY", busA.oVGA_Y, 0);

        // One-line metrics on the default raster; pixel at counter n reaches the pins at n+2.
        hsFirstLow = -1; hsLowLine0 = 0; hsLowTotal = 0; blankHighLine0 = 0;
        redBad = 0; redBlankZero = 0; coordBad = 0;
        for (int m = 1; m <= 2401; m++) begin
            if (busA.oVGA_X != 10'(m % 800) || busA.oVGA_Y != 10'(m / 800)) coordBad++;
            if (busA.oVGA_R != busA.oVGA_BLANK_N) redBad++;
            if (busA.oVGA_HS == 1'b0) begin
                if (hsFirstLow < 0) hsFirstLow = m;
                if (m >= 2 && m < 802) hsLowLine0++;
                if (m >= 2) hsLowTotal++;
            end
            if (m >= 2 && m < 802) begin
                if (busA.oVGA_BLANK_N) blankHighLine0++;
                if (!busA.oVGA_BLANK_N && !busA.oVGA_R) redBlankZero++;
            end
            @(negedge iVGA_CLK);
        end
        checkOutput("coordTrack", coordBad, 0);
        checkOutput("hsFirstLow", hsFirstLow, 658);
        checkOutput("hsLowLine0", hsLowLine0, 96);
        checkOutput("hsLow3Lines", hsLowTotal, 288);
        checkOutput("blankHighLine", blankHighLine0, 640);
        checkOutput("redMask", redBad, 0);
        checkOutput("redBlankZero", redBlankZero, 160);

        // Asynchronous reset in the middle of a visible line.
        found = 1'b0;
        for (int k = 0; k < 1600 && !found; k++) begin
            if (busA.oVGA_X == 10'd400) found = 1'b1;
            else @(negedge iVGA_CLK);
        end
        checkOutput("midResetReach", found, 1);
        checkOutput("preResetR", busA.oVGA_R, 1);
        checkOutput("preResetBlankN", busA.oVGA_BLANK_N, 1);
        #5 reset = 1'b1;
        #1;
        checkOutput("asyncX", busA.oVGA_X, 0);
        checkOutput("asyncY", busA.oVGA_Y, 0);
        checkOutput("asyncR", busA.oVGA_R, 0);
        checkOutput("asyncBlankN", busA.oVGA_BLANK_N, 0);
        checkOutput("asyncHS", busA.oVGA_HS, 1);
        repeat (3) @(negedge iVGA_CLK);
        reset = 1'b0;
        @(negedge iVGA_CLK);
        checkOutput("restartX", busA.oVGA_X, 1);
        checkOutput("restartY", busA.oVGA_Y, 0);

        // Two frames of the 136x13 raster with a three-cycle colour stage (pins at n+4).
        vsLowFrame0 = 0; tickCount = 0; firstTick = -1; secondTick = -1;
        wrapGood = 0; wrapBad = 0; greenBad = 0; greenPulses = 0; prevX = 0; prevY = 0;
        for (int m = 1; m <= 3546; m++) begin
            if (busB.oVGA_Y >= 10'd13) wrapBad++;
            if (prevX == 135 && prevY == 12) begin
                if (busB.oVGA_X == 10'd0 && busB.oVGA_Y == 10'd0) wrapGood++;
                else wrapBad++;
            end
            prevX = int'(busB.oVGA_X);
            prevY = int'(busB.oVGA_Y);
            if (m >= 4) begin
                expG = ((m - 4) % 136 == 100) && (((m - 4) / 136) % 13 < 6);
                if (busB.oVGA_G != expG) greenBad++;
                if (busB.oVGA_G) greenPulses++;
            end
            if (m >= 4 && m < 1772 && !busB.oVGA_VS) vsLowFrame0++;
            if (busB.oFrame_Tick) begin
                tickCount++;
                if (firstTick < 0) firstTick = m;
                else if (secondTick < 0) secondTick = m;
            end
            @(negedge iVGA_CLK);
        end
        checkOutput("wrapOneEdge", wrapGood, 2);
        checkOutput("wrapBad", wrapBad, 0);
        checkOutput("greenAlign", greenBad, 0);
        checkOutput("greenPulses", greenPulses, 12);
        checkOutput("vsLowFrame", vsLowFrame0, 272);
        checkOutput("tickCount", tickCount, 2);
        checkOutput("firstTick", firstTick, 817);
        checkOutput("tickSpacing", secondTick - firstTick, 1768);

        // 256 frames of the 7x5 raster for the frame counter.
        applyStimulus(3);
        ticks = 0; firstTickT = -1; cntBad = 0; tickWideBad = 0; prevTick = 1'b0; done = 1'b0;
        for (int m = 0; m < 9300 && !done; m++) begin
            if (busT.oFrame_Tick) begin
                ticks++;
                if (firstTickT < 0) firstTickT = m;
                if (prevTick) tickWideBad++;
            end else begin
                if (busT.oFrame_Cnt != 8'(CNT_EN ? ticks % 256 : 0)) cntBad++;
                if (prevTick && ticks == 1) checkOutput("cntAfter1", busT.oFrame_Cnt, CNT_EN ? 1 : 0);
                if (prevTick && ticks == 256) begin
                    checkOutput("cntWrap256", busT.oFrame_Cnt, 0);
                    done = 1'b1;
                end
            end
            prevTick = busT.oFrame_Tick;
            @(negedge iVGA_CLK);
        end
        checkOutput("tinyDone", done, 1);
        checkOutput("tinyFirstTick", firstTickT, 15);
        checkOutput("tinyTickWidth", tickWideBad, 0);
        checkOutput("frameCnt", cntBad, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
